or16_accum: RTL and testbench
=============================

Name: or16_accum

Overview:
- Sequential stage directly downstream of the 16-bit bitwise-OR datapath.
- Collects a frame of COUNT consecutive 16-bit words and reduces them by bitwise OR into one 16-bit result.
- Presents the result on a valid/ready output port.
- Used as a sticky-flag / event-mask collector: any bit set in any word of the frame is set in the result.

Parameters:
- COUNT, 4, words per frame; legal range 1..255.
- CW, 8, width of the frame counter; must satisfy 2^CW > COUNT.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous reset, active low.
- in_data  input  16  word to accumulate.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  block can accept in_data this cycle.
- clr  input  1  synchronous frame abort/clear.
- out_data  output  16  OR-reduction of the completed frame.
- out_valid  output  1  out_data holds a completed frame.
- out_ready  input  1  downstream accepts out_data.
- cnt  output  CW  words accepted in the current frame.
- busy  output  1  high when cnt != 0 or out_valid = 1.

Behaviour:
- Clock and reset: one clock, clk. Reset is rst_n, asynchronous and active low.
- Reset values, applied immediately on rst_n low: state IDLE, acc = 0, cnt = 0, out_data = 0, out_valid = 0, busy = 0. These also apply when reset is asserted mid-frame; the partial frame is discarded.
- Handshakes:
  - Input accept = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
- in_ready is combinational: in_ready = !out_valid | out_ready. It is 0 while a result is held and not yet taken.
- States:
  - IDLE: cnt = 0, no output pending.
  - ACCUM: 0 < cnt < COUNT.
  - HOLD: out_valid = 1.
- IDLE or ACCUM, on accept:
  - acc <= (cnt == 0 ? in_data : acc | in_data).
  - cnt <= cnt + 1.
- Accept of the COUNT-th word:
  - out_data <= acc | in_data (in_data alone if COUNT = 1).
  - out_valid <= 1, cnt <= 0, acc <= 0, go to HOLD.
  - Latency: out_valid rises on the first edge after the final accept.
- HOLD:
  - out_data is stable until transfer.
  - On transfer with no accept: out_valid <= 0, go to IDLE.
  - Transfer and accept in the same cycle: the accepted word starts a new frame (acc <= in_data, cnt <= 1, state ACCUM, out_valid <= 0).
  - If COUNT = 1, that word becomes the new result instead (out_data <= in_data, out_valid stays 1).
  - Sustained throughput is therefore one word per cycle.
- No accept without in_valid: acc and cnt hold.
- In IDLE/ACCUM, out_valid = 0 and out_data keeps its last value. This value is not meaningful.
- clr has the highest priority below reset.
  - On the edge where clr = 1: acc <= 0, cnt <= 0, out_valid <= 0, state IDLE.
  - A word presented in the same cycle is dropped, even though in_ready may read 1.
  - A held result is discarded even if out_ready = 1.
- Counter: cnt never exceeds COUNT-1 and does not wrap. It returns to 0 only at frame completion, clr, or reset.
- The datapath is pure bitwise OR, 16 bits. There is no carry and no width growth.

Test Plan:
- Reset: assert rst_n = 0 asynchronously mid-frame, after cnt = 2 -> outputs 0, cnt = 0, and in_ready = 1 after release.
- Basic frame, COUNT = 4: words 0x0001, 0x0010, 0x0100, 0x1000 on consecutive cycles, out_ready = 1 -> one cycle later out_valid = 1, out_data = 0x1111; out_valid drops next cycle.
- Backpressure: complete a frame producing 0x00F0 with out_ready = 0 for 5 cycles -> in_ready = 0, out_data stable at 0x00F0, extra in_valid words ignored; raise out_ready -> transfer, then in_ready = 1.
- Back-to-back: two frames streamed with no gaps, second frame 0xA000, 0x0A00, 0x00A0, 0x000A, out_ready = 1 -> results 0x1111 then 0xAAAA with no dropped word.
- clr mid-frame: after 0xFFFF and 0x0001, assert clr with in_valid = 1 and in_data = 0x8000 -> cnt = 0; next frame 0x0002 x4 yields 0x0002.
- COUNT = 1: words 0x1234, 0x5678 streamed with out_ready = 1 -> out_data 0x1234 then 0x5678 on successive cycles, out_valid held high.

Source files
------------

// File: rtl/or16_accum.sv
// Frame accumulator: ORs COUNT consecutive 16-bit words into one result and
// offers it on a valid/ready port, with synchronous abort (clr).
module or16_accum #(
    parameter int COUNT = 4,
    parameter int CW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [15:0]   in_data,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          clr,
    output logic [15:0]   out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] cnt,
    output logic          busy
);

    // Handshake contract: a word is taken on a rising edge where in_valid & in_ready,
    // and a result leaves on a rising edge where out_valid & out_ready. in_ready is
    // combinational so a held result and a new word can swap in the same cycle.

    localparam logic [CW-1:0] LAST = CW'(COUNT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t        state, state_next;
    logic [15:0]   acc, acc_next;
    logic [CW-1:0] cnt_next;
    logic [15:0]   out_data_next;

    logic          accept;
    logic          transfer;
    logic [15:0]   merged;

    assign out_valid = (state == HOLD);
    assign in_ready  = !out_valid | out_ready;
    assign accept    = in_valid & in_ready;
    assign transfer  = out_valid & out_ready;
    assign busy      = (cnt != '0) | out_valid;

    // The first word of a frame replaces acc rather than ORing into stale contents.
    assign merged = (cnt == '0) ? in_data : (acc | in_data);

    always_comb begin
        state_next    = state;
        acc_next      = acc;
        cnt_next      = cnt;
        out_data_next = out_data;

        if (clr) begin
            state_next = IDLE;
            acc_next   = '0;
            cnt_next   = '0;
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    if (accept) begin
                        if (cnt == LAST) begin
                            out_data_next = merged;
                            acc_next      = '0;
                            cnt_next      = '0;
                            state_next    = HOLD;
                        end else begin
                            acc_next   = merged;
                            cnt_next   = cnt + CW'(1);
                            state_next = ACCUM;
                        end
                    end
                end

                HOLD: begin
                    // While holding, in_ready equals out_ready, so accept implies transfer.
                    if (transfer && accept) begin
                        if (COUNT == 1) begin
                            out_data_next = in_data;
                            state_next    = HOLD;
                        end else begin
                            acc_next   = in_data;
                            cnt_next   = CW'(1);
                            state_next = ACCUM;
                        end
                    end else if (transfer) begin
                        state_next = IDLE;
                    end
                end

                default: begin
                    state_next = IDLE;
                    acc_next   = '0;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            acc      <= '0;
            cnt      <= '0;
            out_data <= '0;
        end else begin
            state    <= state_next;
            acc      <= acc_next;
            cnt      <= cnt_next;
            out_data <= out_data_next;
        end
    end

endmodule

// File: tb/tb_or16_accum.sv
// Directed bench for or16_accum: a COUNT=4 instance for the main scenarios and a
// COUNT=1 instance for the single-word-frame case.
module tb_or16_accum;

    logic        clk;
    logic        rst_n;

    logic [15:0] a_in_data;
    logic        a_in_valid;
    logic        a_in_ready;
    logic        a_clr;
    logic [15:0] a_out_data;
    logic        a_out_valid;
    logic        a_out_ready;
    logic [7:0]  a_cnt;
    logic        a_busy;

    logic [15:0] b_in_data;
    logic        b_in_valid;
    logic        b_in_ready;
    logic        b_clr;
    logic [15:0] b_out_data;
    logic        b_out_valid;
    logic        b_out_ready;
    logic [7:0]  b_cnt;
    logic        b_busy;

    int n_checks = 0;
    int n_fail   = 0;

    or16_accum #(.COUNT(4), .CW(8)) dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (a_in_data),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .clr       (a_clr),
        .out_data  (a_out_data),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .cnt       (a_cnt),
        .busy      (a_busy)
    );

    or16_accum #(.COUNT(1), .CW(8)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (b_in_data),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .clr       (b_clr),
        .out_data  (b_out_data),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .cnt       (b_cnt),
        .busy      (b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%04h expected=0x%04h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [15:0] d);
        a_in_data  = d;
        a_in_valid = 1'b1;
        step();
    endtask

    initial begin
        rst_n       = 1'b0;
        a_in_data   = 16'h0;
        a_in_valid  = 1'b0;
        a_clr       = 1'b0;
        a_out_ready = 1'b0;
        b_in_data   = 16'h0;
        b_in_valid  = 1'b0;
        b_clr       = 1'b0;
        b_out_ready = 1'b0;

        // Reset state
        #1;
        check("rst_out_valid", 16'(a_out_valid), 16'h0);
        check("rst_out_data",  a_out_data,       16'h0);
        check("rst_cnt",       16'(a_cnt),       16'h0);
        check("rst_busy",      16'(a_busy),      16'h0);
        check("rst_in_ready",  16'(a_in_ready),  16'h1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Asynchronous reset in the middle of a frame
        send_a(16'h0003);
        check("mid_cnt1", 16'(a_cnt), 16'h1);
        send_a(16'h0004);
        check("mid_cnt2", 16'(a_cnt), 16'h2);
        check("mid_busy", 16'(a_busy), 16'h1);
        a_in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_cnt",       16'(a_cnt),       16'h0);
        check("arst_busy",      16'(a_busy),      16'h0);
        check("arst_out_valid", 16'(a_out_valid), 16'h0);
        check("arst_out_data",  a_out_data,       16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("arst_in_ready", 16'(a_in_ready), 16'h1);

        // Basic frame
        a_out_ready = 1'b1;
        send_a(16'h0001);
        send_a(16'h0010);
        send_a(16'h0100);
        check("basic_cnt3",      16'(a_cnt),       16'h3);
        check("basic_pre_valid", 16'(a_out_valid), 16'h0);
        send_a(16'h1000);
        check("basic_valid", 16'(a_out_valid), 16'h1);
        check("basic_data",  a_out_data,       16'h1111);
        check("basic_cnt0",  16'(a_cnt),       16'h0);
        a_in_valid = 1'b0;
        step();
        check("basic_drop_valid", 16'(a_out_valid), 16'h0);
        check("basic_idle_busy",  16'(a_busy),      16'h0);

        // Backpressure: result held while out_ready is low, extra words refused
        a_out_ready = 1'b0;
        send_a(16'h0010);
        send_a(16'h0020);
        send_a(16'h0040);
        send_a(16'h0080);
        check("bp_valid",    16'(a_out_valid), 16'h1);
        check("bp_data",     a_out_data,       16'h00F0);
        check("bp_in_ready", 16'(a_in_ready),  16'h0);
        for (int i = 0; i < 5; i++) begin
            send_a(16'hFFFF);
            check("bp_hold_valid",    16'(a_out_valid), 16'h1);
            check("bp_hold_data",     a_out_data,       16'h00F0);
            check("bp_hold_in_ready", 16'(a_in_ready),  16'h0);
            check("bp_hold_cnt",      16'(a_cnt),       16'h0);
        end
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", 16'(a_in_ready), 16'h1);
        step();
        check("bp_xfer_valid",    16'(a_out_valid), 16'h0);
        check("bp_xfer_in_ready", 16'(a_in_ready),  16'h1);
        check("bp_xfer_cnt",      16'(a_cnt),       16'h0);

        // Back-to-back frames with no gap
        send_a(16'h0001);
        send_a(16'h0010);
        send_a(16'h0100);
        send_a(16'h1000);
        check("b2b_valid1", 16'(a_out_valid), 16'h1);
        check("b2b_data1",  a_out_data,       16'h1111);
        send_a(16'hA000);
        check("b2b_swap_valid", 16'(a_out_valid), 16'h0);
        check("b2b_swap_cnt",   16'(a_cnt),       16'h1);
        send_a(16'h0A00);
        send_a(16'h00A0);
        check("b2b_cnt3", 16'(a_cnt), 16'h3);
        send_a(16'h000A);
        check("b2b_valid2", 16'(a_out_valid), 16'h1);
        check("b2b_data2",  a_out_data,       16'hAAAA);
        a_in_valid = 1'b0;
        step();
        check("b2b_end_valid", 16'(a_out_valid), 16'h0);

        // clr mid-frame drops the partial frame and the word presented with it
        send_a(16'hFFFF);
        send_a(16'h0001);
        check("clr_pre_cnt", 16'(a_cnt), 16'h2);
        a_clr = 1'b1;
        send_a(16'h8000);
        a_clr = 1'b0;
        check("clr_cnt",       16'(a_cnt),       16'h0);
        check("clr_busy",      16'(a_busy),      16'h0);
        check("clr_out_valid", 16'(a_out_valid), 16'h0);
        for (int i = 0; i < 4; i++) send_a(16'h0002);
        check("clr_next_valid", 16'(a_out_valid), 16'h1);
        check("clr_next_data",  a_out_data,       16'h0002);
        a_in_valid = 1'b0;
        step();

        // clr discards a held result even with out_ready high
        a_out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_a(16'h0003);
        check("clr_hold_valid", 16'(a_out_valid), 16'h1);
        a_in_valid  = 1'b0;
        a_clr       = 1'b1;
        a_out_ready = 1'b1;
        step();
        a_clr = 1'b0;
        check("clr_hold_drop", 16'(a_out_valid), 16'h0);
        check("clr_hold_cnt",  16'(a_cnt),       16'h0);

        // COUNT = 1: every word is its own frame
        b_out_ready = 1'b1;
        b_in_valid  = 1'b1;
        b_in_data   = 16'h1234;
        step();
        check("c1_valid1", 16'(b_out_valid), 16'h1);
        check("c1_data1",  b_out_data,       16'h1234);
        check("c1_cnt",    16'(b_cnt),       16'h0);
        b_in_data = 16'h5678;
        step();
        check("c1_valid2", 16'(b_out_valid), 16'h1);
        check("c1_data2",  b_out_data,       16'h5678);
        b_in_valid = 1'b0;
        step();
        check("c1_drop_valid", 16'(b_out_valid), 16'h0);
        b_out_ready = 1'b0;
        b_in_valid  = 1'b1;
        b_in_data   = 16'h00FF;
        step();
        b_in_data = 16'h1111;
        step();
        check("c1_bp_in_ready", 16'(b_in_ready), 16'h0);
        check("c1_bp_data",     b_out_data,      16'h00FF);
        b_in_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
